// File: rtl/rob_queue.sv
// rob_queue: reorder buffer, allocates in order, accepts out-of-order writeback, commits in order; optional macro ROB_WB_BYPASS_EN forwards same-cycle writebacks to the operand queries; ports: clk/rst/rdy/Clear_flag control, alloc_* dispatch, wb_*/slb_wb_* writeback, qry_* lookups, commit_*/flush_* registered commit outputs
module rob_queue #(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             Clear_flag,
  input  logic             alloc_valid,
  input  logic [5:0]       alloc_ordertype,
  input  logic [4:0]       alloc_dest,
  input  logic [31:0]      alloc_pc,
  output logic [IDX_W-1:0] alloc_tail,
  output logic             rob_full,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_idx,
  input  logic [31:0]      wb_value,
  input  logic             wb_jump_valid,
  input  logic [31:0]      wb_jumppc,
  input  logic             slb_wb_valid,
  input  logic [IDX_W-1:0] slb_wb_idx,
  input  logic [31:0]      slb_wb_value,
  input  logic [IDX_W-1:0] qry_idx_a,
  input  logic [IDX_W-1:0] qry_idx_b,
  output logic             qry_ready_a,
  output logic             qry_ready_b,
  output logic [31:0]      qry_value_a,
  output logic [31:0]      qry_value_b,
  output logic             commit_valid,
  output logic [IDX_W-1:0] commit_idx,
  output logic [4:0]       commit_dest,
  output logic [31:0]      commit_value,
  output logic             flush_req,
  output logic [31:0]      flush_pc
);
  logic [DEPTH-1:0] busy, ready, jump;
  logic [5:0]       ordertype [DEPTH];
  logic [4:0]       dest      [DEPTH];
  logic [31:0]      pc        [DEPTH];
  logic [31:0]      value     [DEPTH];
  logic [31:0]      jumppc    [DEPTH];
  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count;
  logic             do_alloc, do_commit;
  assign alloc_tail = tail;
  assign rob_full   = count == (IDX_W+1)'(DEPTH);
  assign do_alloc   = alloc_valid && !rob_full;
  assign do_commit  = busy[head] && ready[head];
`ifdef ROB_WB_BYPASS_EN
  always_comb begin
    qry_ready_a = busy[qry_idx_a] && (ready[qry_idx_a] || (wb_valid && wb_idx == qry_idx_a) || (slb_wb_valid && slb_wb_idx == qry_idx_a));
    qry_ready_b = busy[qry_idx_b] && (ready[qry_idx_b] || (wb_valid && wb_idx == qry_idx_b) || (slb_wb_valid && slb_wb_idx == qry_idx_b));
    qry_value_a = (busy[qry_idx_a] && wb_valid && wb_idx == qry_idx_a) ? wb_value :
                  (busy[qry_idx_a] && slb_wb_valid && slb_wb_idx == qry_idx_a) ? slb_wb_value : value[qry_idx_a];
    qry_value_b = (busy[qry_idx_b] && wb_valid && wb_idx == qry_idx_b) ? wb_value :
                  (busy[qry_idx_b] && slb_wb_valid && slb_wb_idx == qry_idx_b) ? slb_wb_value : value[qry_idx_b];
  end
`else
  always_comb begin
    qry_ready_a = busy[qry_idx_a] && ready[qry_idx_a];
    qry_ready_b = busy[qry_idx_b] && ready[qry_idx_b];
    qry_value_a = value[qry_idx_a];
    qry_value_b = value[qry_idx_b];
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      busy <= '0;
      ready <= '0;
      jump <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ordertype[i] <= '0;
        dest[i] <= '0;
        pc[i] <= '0;
        value[i] <= '0;
        jumppc[i] <= '0;
      end
      commit_valid <= 1'b0;
      commit_idx <= '0;
      commit_dest <= '0;
      commit_value <= '0;
      flush_req <= 1'b0;
      flush_pc <= '0;
    end else if (!rdy) begin
      commit_valid <= 1'b0;
      flush_req <= 1'b0;
    end else if (Clear_flag) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      busy <= '0;
      commit_valid <= 1'b0;
      flush_req <= 1'b0;
    end else begin
      // SLB first so a same-index RS writeback overrides it
      if (slb_wb_valid && busy[slb_wb_idx]) begin
        value[slb_wb_idx] <= slb_wb_value;
        ready[slb_wb_idx] <= 1'b1;
      end
      if (wb_valid && busy[wb_idx]) begin
        value[wb_idx] <= wb_value;
        ready[wb_idx] <= 1'b1;
        if (wb_jump_valid) begin
          jump[wb_idx] <= 1'b1;
          jumppc[wb_idx] <= wb_jumppc;
        end
      end
      // tail only coincides with a busy entry when full, so alloc never collides with writeback or commit
      if (do_alloc) begin
        busy[tail] <= 1'b1;
        ready[tail] <= 1'b0;
        jump[tail] <= 1'b0;
        ordertype[tail] <= alloc_ordertype;
        dest[tail] <= alloc_dest;
        pc[tail] <= alloc_pc;
        tail <= tail + 1'b1;
      end
      commit_valid <= do_commit;
      flush_req <= do_commit && jump[head];
      if (do_commit) begin
        busy[head] <= 1'b0;
        head <= head + 1'b1;
        commit_idx <= head;
        commit_dest <= dest[head];
        commit_value <= value[head];
        if (jump[head]) flush_pc <= jumppc[head];
      end
      count <= count + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_commit);
    end
  end
endmodule
